vfr_stream_input: RTL

VFR_STREAM_INPUT -- requirements
Module: vfr_stream_input

---
 rtl/vfr_stream_pkg.sv | 18 +
 rtl/vfr_ctrl_pkt_decoder.sv | 92 +++++++++
 rtl/vfr_stream_input.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vfr_stream_pkg.sv
// Shared definitions for the vfr_stream_input block.
//   PKT_IMAGE / PKT_CONTROL : packet-type codes carried in data[3:0] of a sop beat
//   CTRL_NIBBLES            : payload nibbles needed for a complete control decode
//   state_e                 : packet-tracking state of the input stage
package vfr_stream_pkg;

  localparam logic [3:0] PKT_IMAGE    = 4'h0;
  localparam logic [3:0] PKT_CONTROL  = 4'hF;
  localparam logic [3:0] CTRL_NIBBLES = 4'd9;

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    IMAGE    = 2'd1,
    CONTROL  = 2'd2,
    DISCARD  = 2'd3
  } state_e;

endpackage

// File: rtl/vfr_ctrl_pkt_decoder.sv
// Control-packet decoder: collects payload nibbles MSB-first into
// width (nibbles 0-3), height (nibbles 4-7) and interlace (nibble 8).
// The decode is published only when the packet ends with at least 9 nibbles.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : accepted sop beat (restarts nibble collection)
//   beat            : accepted payload beat of a control packet
//   eop             : end-of-packet flag of the current beat
//   nibble          : data[3:0] of the current beat
//   ctrl_width/height/interlace : last completed decode
//   ctrl_valid      : one-cycle pulse when a decode completes
module vfr_ctrl_pkt_decoder
  import vfr_stream_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        beat,
  input  logic        eop,
  input  logic [3:0]  nibble,
  output logic [15:0] ctrl_width,
  output logic [15:0] ctrl_height,
  output logic [3:0]  ctrl_interlace,
  output logic        ctrl_valid
);

  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] wsh_q, wsh_d;
  logic [15:0] hsh_q, hsh_d;
  logic [3:0]  ish_q, ish_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [3:0]  il_q, il_d;
  logic        valid_q, valid_d;

  always_comb begin
    cnt_d    = cnt_q;
    wsh_d    = wsh_q;
    hsh_d    = hsh_q;
    ish_d    = ish_q;
    width_d  = width_q;
    height_d = height_q;
    il_d     = il_q;
    valid_d  = 1'b0;
    if (start) begin
      cnt_d = 4'd0;
    end else if (beat) begin
      // Counter saturates at CTRL_NIBBLES; surplus nibbles are ignored.
      if (cnt_q < CTRL_NIBBLES) begin
        if (cnt_q < 4'd4)      wsh_d = {wsh_q[11:0], nibble};
        else if (cnt_q < 4'd8) hsh_d = {hsh_q[11:0], nibble};
        else                   ish_d = nibble;
        cnt_d = cnt_q + 4'd1;
      end
      // The eop beat carries a nibble too, so judge completeness after it.
      if (eop && (cnt_d == CTRL_NIBBLES)) begin
        width_d  = wsh_d;
        height_d = hsh_d;
        il_d     = ish_d;
        valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 4'd0;
      wsh_q    <= 16'd0;
      hsh_q    <= 16'd0;
      ish_q    <= 4'd0;
      width_q  <= 16'd0;
      height_q <= 16'd0;
      il_q     <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wsh_q    <= wsh_d;
      hsh_q    <= hsh_d;
      ish_q    <= ish_d;
      width_q  <= width_d;
      height_q <= height_d;
      il_q     <= il_d;
      valid_q  <= valid_d;
    end
  end

  assign ctrl_width     = width_q;
  assign ctrl_height    = height_q;
  assign ctrl_interlace = il_q;
  assign ctrl_valid     = valid_q;

endmodule

// File: rtl/vfr_stream_input.sv
// Avalon-ST video input stage. Tracks packet boundaries, forwards image
// packets (header beat included) to the internal stream one cycle after
// acceptance, drops control and unknown packets, and flags beats that
// arrive outside a packet or sops that abandon an open packet.
// Optional feature macro: VFR_STREAM_INPUT_CTRL_DECODE_EN -- when defined,
// control packets are decoded into ctrl_width/height/interlace; otherwise
// they are dropped like unknown packets and ctrl_* read as zero.
// Ports:
//   clk, rst_n                           : clock, asynchronous active-low reset
//   din_valid/data/sop/eop, din_ready    : video sink (ready is registered)
//   int_valid/data/sop/eop, int_ready    : internal image-packet stream
//   enable                               : permits starting a new packet
//   synced                               : idle at a packet boundary with enable low
//   ctrl_width/height/interlace, ctrl_valid : control-packet decode results
//   sop_err                              : pulse on a misplaced beat or sop
module vfr_stream_input
  import vfr_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din_valid,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_sop,
  input  logic                  din_eop,
  output logic                  din_ready,
  output logic                  int_valid,
  output logic [DATA_WIDTH-1:0] int_data,
  output logic                  int_sop,
  output logic                  int_eop,
  input  logic                  int_ready,
  input  logic                  enable,
  output logic                  synced,
  output logic [15:0]           ctrl_width,
  output logic [15:0]           ctrl_height,
  output logic [3:0]            ctrl_interlace,
  output logic                  ctrl_valid,
  output logic                  sop_err
);

  state_e                state_q, state_d;
  logic                  din_ready_q, din_ready_d;
  logic                  int_valid_q, int_valid_d;
  logic [DATA_WIDTH-1:0] int_data_q, int_data_d;
  logic                  int_sop_q, int_sop_d;
  logic                  int_eop_q, int_eop_d;
  logic                  sop_err_q, sop_err_d;

  logic       accept;
  logic       gate;
  logic       fwd;
  logic [3:0] pkt_type;

  always_comb begin
    accept   = din_valid & din_ready_q;
    pkt_type = din_data[3:0];
    // A new packet may only start while enabled; an open packet always drains.
    gate        = (state_q == WAIT_SOP) ? enable : 1'b1;
    din_ready_d = int_ready & gate;

    // Forward image headers (from any state) and image payload beats.
    fwd         = accept & (din_sop ? (pkt_type == PKT_IMAGE) : (state_q == IMAGE));
    int_valid_d = fwd;
    int_sop_d   = fwd & din_sop;
    int_eop_d   = fwd & din_eop;
    int_data_d  = fwd ? din_data : int_data_q;

    // Payload outside a packet, or a sop cutting an open packet short.
    sop_err_d = accept & ((state_q == WAIT_SOP) ? ~din_sop : din_sop);

    state_d = state_q;
    if (accept) begin
      if (din_sop) begin
        if (din_eop)                      state_d = WAIT_SOP;
        else if (pkt_type == PKT_IMAGE)   state_d = IMAGE;
`ifdef VFR_STREAM_INPUT_CTRL_DECODE_EN
        else if (pkt_type == PKT_CONTROL) state_d = CONTROL;
`endif
        else                              state_d = DISCARD;
      end else if (din_eop && (state_q != WAIT_SOP)) begin
        state_d = WAIT_SOP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_SOP;
      din_ready_q <= 1'b0;
      int_valid_q <= 1'b0;
      int_data_q  <= '0;
      int_sop_q   <= 1'b0;
      int_eop_q   <= 1'b0;
      sop_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_ready_q <= din_ready_d;
      int_valid_q <= int_valid_d;
      int_data_q  <= int_data_d;
      int_sop_q   <= int_sop_d;
      int_eop_q   <= int_eop_d;
      sop_err_q   <= sop_err_d;
    end
  end

`ifdef VFR_STREAM_INPUT_CTRL_DECODE_EN
  vfr_ctrl_pkt_decoder u_ctrl_dec (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (accept & din_sop),
    .beat           (accept & ~din_sop & (state_q == CONTROL)),
    .eop            (din_eop),
    .nibble         (din_data[3:0]),
    .ctrl_width     (ctrl_width),
    .ctrl_height    (ctrl_height),
    .ctrl_interlace (ctrl_interlace),
    .ctrl_valid     (ctrl_valid)
  );
`else
  assign ctrl_width     = 16'd0;
  assign ctrl_height    = 16'd0;
  assign ctrl_interlace = 4'd0;
  assign ctrl_valid     = 1'b0;
`endif

  assign din_ready = din_ready_q;
  assign int_valid = int_valid_q;
  assign int_data  = int_data_q;
  assign int_sop   = int_sop_q;
  assign int_eop   = int_eop_q;
  assign sop_err   = sop_err_q;
  assign synced    = (state_q == WAIT_SOP) & ~enable;

endmodule
